// File: rtl/control_cmd_readback_tx_pkg.sv
// Shared parameters, types and helper functions for the pixel readback transmitter.
// Define READBACK_HEADER_EN to include the row/column header state in readback_state_t.
package params;
    localparam int unsigned BYTES_PER_PIXEL = 3;
endpackage

package types;
    localparam int unsigned ROW_BITS = 6;
    localparam int unsigned COL_BITS = 10;

    typedef logic [ROW_BITS-1:0] row_addr_t;
    typedef logic [COL_BITS-1:0] col_addr_t;

    typedef enum logic [2:0] {
        IDLE,
`ifdef READBACK_HEADER_EN
        HDR,
`endif
        RD,
        WAIT,
        SEND,
        FIN
    } readback_state_t;
endpackage

package calc;
    // A single colour byte still needs a one-bit select port.
    function automatic int unsigned num_pixelcolorselect_bits(int unsigned bytes_per_pixel);
        return (bytes_per_pixel <= 1) ? 1 : $clog2(bytes_per_pixel);
    endfunction

    function automatic int unsigned num_col_bytes();
        return ($bits(types::col_addr_t) + 7) / 8;
    endfunction

    function automatic logic [7:0] col_byte(types::col_addr_t col, int unsigned idx);
        logic [31:0] ext;
        ext = 32'(col);
        return 8'(ext >> (8 * idx));
    endfunction
endpackage

// File: rtl/control_cmd_readback_tx_byte_tx_hold.sv
// Single-entry valid/ready output register: load, hold while stalled, clear on accept.
module byte_tx_hold (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data
);

    // NOTE: state registers use non-blocking assignments and a synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (load) begin
            tx_valid <= 1'b1;
            tx_data  <= load_data;
        end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/control_cmd_readback_tx.sv
// Reads one pixel's colour bytes from frame RAM and streams them MSB byte first.
// Define READBACK_HEADER_EN to prefix each pixel with its row byte and column bytes.
module control_cmd_readback_tx
    import types::*;
#(
    parameter int unsigned BYTES_PER_PIXEL = params::BYTES_PER_PIXEL,
    parameter int unsigned RAM_LATENCY     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  row_addr_t  row,
    input  col_addr_t  column,
    output row_addr_t  ram_row,
    output col_addr_t  ram_column,
    output logic [calc::num_pixelcolorselect_bits(BYTES_PER_PIXEL)-1:0] ram_pixel,
    output logic       ram_read_enable,
    input  logic [7:0] ram_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    localparam int unsigned       PIX_W     = calc::num_pixelcolorselect_bits(BYTES_PER_PIXEL);
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(BYTES_PER_PIXEL - 1);
    localparam logic [1:0]        WAIT_LAST = 2'(RAM_LATENCY - 1);

    readback_state_t state_q, state_d;
    logic [1:0]      wait_cnt_q;
    logic            hold_load;
    logic [7:0]      hold_data;
    logic            handshake;

`ifdef READBACK_HEADER_EN
    localparam logic [3:0] COL_BYTES = 4'(calc::num_col_bytes());
    logic [3:0] col_idx_q;   // column bytes already loaded into the output register
`endif

    assign handshake       = tx_valid && tx_ready;
    assign ram_read_enable = (state_q == RD);
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == FIN);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        hold_load = 1'b0;
        hold_data = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef READBACK_HEADER_EN
                    hold_load = 1'b1;
                    hold_data = 8'(row);
                    state_d   = HDR;
`else
                    state_d   = RD;
`endif
                end
            end
`ifdef READBACK_HEADER_EN
            HDR: begin
                if (handshake) begin
                    if (col_idx_q == COL_BYTES) begin
                        state_d = RD;
                    end else begin
                        hold_load = 1'b1;
                        hold_data = calc::col_byte(ram_column, 32'(col_idx_q));
                    end
                end
            end
`endif
            RD:   state_d = WAIT;
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    hold_load = 1'b1;
                    hold_data = ram_data;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (handshake) state_d = (ram_pixel == '0) ? FIN : RD;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address and pixel select stay put from RD through the capture cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            ram_row    <= '0;
            ram_column <= '0;
            ram_pixel  <= '0;
            wait_cnt_q <= '0;
`ifdef READBACK_HEADER_EN
            col_idx_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ram_row    <= row;
                        ram_column <= column;
                        ram_pixel  <= LAST_PIX;
`ifdef READBACK_HEADER_EN
                        col_idx_q  <= '0;
`endif
                    end
                end
`ifdef READBACK_HEADER_EN
                HDR: begin
                    if (handshake && col_idx_q != COL_BYTES) col_idx_q <= col_idx_q + 4'd1;
                end
`endif
                RD:   wait_cnt_q <= '0;
                WAIT: wait_cnt_q <= wait_cnt_q + 2'd1;
                SEND: begin
                    if (handshake && ram_pixel != '0) ram_pixel <= ram_pixel - PIX_W'(1);
                end
                default: ;
            endcase
        end
    end

    byte_tx_hold u_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (hold_load),
        .load_data (hold_data),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data)
    );

endmodule

// File: doc/control_cmd_readback_tx.md
# control_cmd_readback_tx

Transmit side of the pixel command path: given a latched row/column, reads one pixel's colour bytes from frame RAM and serializes them onto a byte-wide valid/ready stream toward the host link. It is the inverse of the readpixel receiver, which consumes the same byte order and writes RAM. The block sits between the command dispatcher, which issues `start`, and the UART/serial TX byte queue.

## Interface
- `BYTES_PER_PIXEL`, default `params::BYTES_PER_PIXEL`: colour bytes per pixel; must be ≥1.
- `RAM_LATENCY`, default 1: cycles from `ram_read_enable` to valid `ram_data`; legal range 1–3.
- `clk`  input  1  system clock.
- `reset`  input  1  reset; synchronous and active-low.
- `start`  input  1  one-cycle request, honoured only in IDLE.
- `row`  input  `types::row_addr_t`  target row, sampled on an accepted `start`.
- `column`  input  `types::col_addr_t`  target column, sampled on an accepted `start`.
- `ram_row`  output  `types::row_addr_t`  RAM read row address.
- `ram_column`  output  `types::col_addr_t`  RAM read column address.
- `ram_pixel`  output  `calc::num_pixelcolorselect_bits(BYTES_PER_PIXEL)`  colour-byte select.
- `ram_read_enable`  output  1  one-cycle read strobe.
- `ram_data`  input  8  RAM read data.
- `tx_data`  output  8  stream byte.
- `tx_valid`  output  1  `tx_data` is valid.
- `tx_ready`  input  1  sink accepts the byte.
- `busy`  output  1  high from the cycle after an accepted `start` until the `done` cycle, inclusive.
- `done`  output  1  one-cycle pulse after the last byte is accepted.

## Operation
- FSM states: IDLE, HDR, RD, WAIT, SEND, FIN.
- IDLE: on `start`, latch `row`/`column`, set byte index to `BYTES_PER_PIXEL-1`, then go to HDR (header enabled) or RD.
- HDR: emit the row byte, then the column bytes. The row byte is zero-extended to 8 bits. Column bytes are emitted LSB first, `ceil($bits(col_addr_t)/8)` of them. Each byte is held until its handshake completes. After the last header byte, go to RD.
- RD: drive the address, pulse `ram_read_enable`, then go to WAIT. `ram_pixel` holds the current index, counting down from `BYTES_PER_PIXEL-1` to 0, so the pixel is sent MSB byte first.
- WAIT: count `RAM_LATENCY` cycles, capture `ram_data` into `tx_data`, then go to SEND.
- SEND: hold `tx_valid`. On `tx_valid && tx_ready`: if the index is 0, go to FIN; otherwise decrement the index and go to RD.
- FIN: pulse `done` for one cycle, then return to IDLE.
- `start` while not in IDLE is ignored, with no queuing.
- `tx_data` must not change while `tx_valid` is high and `tx_ready` is low.
- `ram_row`, `ram_column` and `ram_pixel` are stable from the RD cycle through the capture cycle.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `ram_read_enable`=0, `ram_row`/`ram_column`/`ram_pixel`=0, `busy`=0, `done`=0, FSM in IDLE, index=0.
- Reset asserted mid-transaction aborts it on the next clock edge. No `done` pulse is produced and outputs return to their reset values.
- Start to first header byte: `tx_valid` is high in cycle N+1 after `start` is sampled in cycle N.
- Read strobe to payload byte: `tx_valid` rises at N+RAM_LATENCY+1, where N is the `ram_read_enable` cycle.
- With `tx_ready` held high, each payload byte takes RAM_LATENCY+2 cycles.
- Header bytes, with `tx_ready` held high, take one cycle each.
- `done` is asserted the cycle after the last handshake. IDLE is reached the cycle after `done`, and `start` is accepted from that cycle on.
- `tx_ready` may be high while `tx_valid` is low; no transfer occurs.
- A `start` that arrives in the same cycle as `done` is ignored.

## Configuration
- Macro `READBACK_HEADER_EN`.
- Defined: the HDR state is present; each transaction emits 1 + column_bytes + `BYTES_PER_PIXEL` bytes.
- Undefined: the HDR state is compiled out; IDLE goes directly to RD and only `BYTES_PER_PIXEL` bytes are emitted.

## Structure
- The FSM state enum `readback_state_t` belongs in package `types`.
- The column byte count belongs in `calc` as `num_col_bytes()`.
- One sub-module is natural: `byte_tx_hold`. It is a single-entry valid/ready output register providing load, hold-on-stall and clear-on-accept.

## Test plan
- `BYTES_PER_PIXEL`=2, `RAM_LATENCY`=1, header enabled, `start` with row=5, col=0x0023, RAM returning 0xAB for pixel 1 and 0xCD for pixel 0, `tx_ready`=1 → stream 0x05, 0x23, 0x00 (if 2 column bytes), 0xAB, 0xCD; then one `done` pulse.
- The same transaction with `tx_ready` low for 3 cycles on each byte → `tx_data` stable while stalled, identical byte sequence, no extra `ram_read_enable` pulses.
- Header macro undefined, `RAM_LATENCY`=3 → exactly 2 bytes (0xAB, 0xCD); first `tx_valid` exactly 4 cycles after the first `ram_read_enable`.
- `start` pulsed while `busy`=1 → ignored; exactly one transaction is emitted and `ram_row` is unchanged.
- Reset driven low during WAIT of the second byte → next cycle all outputs are 0, no `done`; a fresh `start` afterwards completes normally.
- Back-to-back: `start` issued the cycle after `done` → accepted; two complete streams with no duplicate or dropped bytes.
